muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M execution unit controller. Sequences a shared shift/add/subtract datapath through iterative multiply (MUL/MULH/MULHSU/MULHU) and restoring divide (DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in the execute stage. Holds the pipeline via `busy` until it emits a one-cycle `done` with the result.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request. Sampled only in IDLE.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  in  XLEN  rs1 operand. Sampled with start.
- srcB  in  XLEN  rs2 operand. Sampled with start.
- flush  in  1  abort the in-flight op (branch/jump redirect).
- busy  out  1  high while in RUN. Combined with start by the hazard unit for the stall.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  op result. Held until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0. Internal accumulators are cleared. Reset mid-RUN aborts with no done.
- States:
  - IDLE: start=1 at cycle T latches funct3, the operand magnitudes and sign flags, then goes to RUN with counter=XLEN.
  - RUN: one iteration per cycle; counter decrements. When counter reaches 1, the next state is FIN.
  - FIN: done=1, result written from the sign-corrected datapath, then back to IDLE.
- Latency: done asserts at T+XLEN+1 (33 cycles for XLEN=32). busy=1 exactly on cycles T+1..T+XLEN.
- start is ignored while busy or in FIN. Back-to-back ops are allowed: start in the cycle after FIN is accepted.
- Signedness:
  - Signed operands (MULH: both; MULHSU: srcA only; DIV/REM: both) are converted to magnitude. The unsigned datapath runs on the magnitudes.
  - Multiply: the 2*XLEN product is negated if the signs differ. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Divide: quotient is negated if sign(srcA)^sign(srcB); remainder takes the sign of srcA.
- Multiply iteration: if the multiplier LSB is 1, add the multiplicand into the upper accumulator; then shift the {acc, multiplier} pair right by 1.
- Divide iteration:
  - Shift {rem, quotient} left by 1 and trial-subtract the divisor.
  - If no borrow, keep the difference and set the quotient LSB to 1.
- Divide-by-zero (required result):
  - DIV/DIVU: result = all ones.
  - REM/REMU: result = srcA.
- Signed overflow (srcA=0x80000000, srcB=-1):
  - DIV: result = 0x80000000.
  - REM: result = 0.
- Without the fast path, both special cases run the full XLEN iterations. FIN then overrides the result from flags latched at start.
- flush:
  - In RUN: return to IDLE the next cycle, no done, result unchanged.
  - In FIN: done still pulses (the instruction already committed).
  - Simultaneous start and flush in IDLE: start is dropped.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined: at start, divide-by-zero, signed overflow, or any multiply with srcA==0 or srcB==0 goes IDLE->FIN directly. done then asserts at T+1 and busy never rises. Results are identical to the slow path.
- Undefined: every op takes XLEN+1 cycles; the datapath-only implementation is smaller.

Test Plan:
- MUL 7 * -3 (srcB=0xFFFFFFFD) -> done at T+33, result 0xFFFFFFEB; busy high for exactly 32 cycles.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000 / -1 -> 0x80000000. REM same operands -> 0. Latency T+1 with MULDIV_FASTPATH_EN, T+33 without.
- Start DIVU, assert flush at T+10 -> IDLE at T+11, no done, result keeps its prior value. A new start at T+12 completes normally.
- rst at T+5 mid-MUL -> all outputs 0 the next cycle. start held high during RUN is ignored; start on the cycle after FIN is accepted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer: RV32M multiply/divide controller driving a shared shift/add/subtract datapath.
// Optional macro MULDIV_FASTPATH_EN: zero-operand multiplies and divide special cases go IDLE->FIN directly.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   acc_q, lo_q, opb_q, spec_q, result_q;
    logic [2:0]        op_q;
    logic              neg_q, rneg_q, spec_vld_q;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic              div0, ovf, mzero, fast_hit, fast_go;
    logic [XLEN-1:0]   a_mag, b_mag, spec_val;

    assign is_div = funct3[2];
    assign a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg  = a_sgn && srcA[XLEN-1];
    assign b_neg  = b_sgn && srcB[XLEN-1];
    assign a_mag  = cond_neg(a_neg, srcA);
    assign b_mag  = cond_neg(b_neg, srcB);

    // Special cases are decided at start; FIN substitutes their result over the datapath's.
    assign div0     = is_div && (srcB == '0);
    assign ovf      = is_div && !funct3[0] && (srcA == MIN_NEG) && (srcB == '1);
    assign mzero    = !is_div && ((srcA == '0) || (srcB == '0));
    assign fast_hit = div0 || ovf || mzero;

    always_comb begin
        spec_val = '0;
        if (div0)
            spec_val = funct3[1] ? srcA : '1;
        else if (ovf)
            spec_val = funct3[1] ? '0 : MIN_NEG;
    end

`ifdef MULDIV_FASTPATH_EN
    assign fast_go = fast_hit;
`else
    assign fast_go = 1'b0;
`endif

    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, div_res, final_res;

    assign mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    assign div_sh   = {acc_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};

    assign prod      = cond_neg2(neg_q, {acc_q, lo_q});
    assign mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_res   = op_q[1] ? cond_neg(rneg_q, acc_q) : cond_neg(neg_q, lo_q);
    assign final_res = spec_vld_q ? spec_q : (op_q[2] ? div_res : mul_res);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start && !flush) state_d = fast_go ? FIN : RUN;
            RUN: begin
                busy = 1'b1;
                if (flush)
                    state_d = IDLE;
                else if (cnt_q == CNT_W'(1))
                    state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = (state_q == FIN) ? final_res : result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            spec_q     <= '0;
            result_q   <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            spec_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start && !flush) begin
                    op_q       <= funct3;
                    neg_q      <= a_neg ^ b_neg;
                    rneg_q     <= a_neg;
                    spec_q     <= spec_val;
                    spec_vld_q <= fast_hit;
                    acc_q      <= '0;
                    lo_q       <= is_div ? a_mag : b_mag;
                    opb_q      <= is_div ? b_mag : a_mag;
                    cnt_q      <= fast_go ? '0 : CNT_W'(XLEN);
                end
                RUN: if (!flush) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Divide: restoring step, quotient bit is the inverted borrow. Multiply: add-then-shift right.
                    if (op_q[2]) begin
                        acc_q <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                    end else begin
                        acc_q <= mul_sum[XLEN:1];
                        lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
                FIN: result_q <= final_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_sequencer: vector table, random ops against an arithmetic model, corner sequences.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] result;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    typedef struct { logic [31:0] res; int at; } sb_t;
    sb_t sbq[$];

    typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t vecs[16];

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
        if (f[2]) return (b == 32'd0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return (a == 32'd0) || (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] qa, qb;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        qa  = a;
        qb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return 32'(qa / qb);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'(qa % qb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hold);
        int  c0, nb;
        bit  got, fast;
        sb_t e;
        fast = is_fast(f, a, b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        srcA   = a;
        srcB   = b;
        c0     = cyc;
        e.res  = exp;
        e.at   = c0 + (fast ? 1 : XLEN + 1);
        sbq.push_back(e);
        nb  = 0;
        got = 1'b0;
        for (int k = 0; k < XLEN + 8; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (hold) begin
                srcA   = $urandom;
                srcB   = $urandom;
                funct3 = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_cycles", 32'(nb), fast ? 32'd0 : 32'(XLEN));
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got %0d checks, want completion", checks);
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b, held;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; srcA = 32'd0; srcB = 32'd0;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2};
        vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[12] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[13] = '{3'b111, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[14] = '{3'b000, 32'd0,        32'd1234,     32'd0};
        vecs[15] = '{3'b001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF};

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue(f, a, b, ref_model(f, a, b), 1'b0);
        end

        // start held through RUN with scrambled inputs, then a back-to-back op in the cycle after FIN
        issue(3'b011, 32'h12345678, 32'h9ABCDEF0, ref_model(3'b011, 32'h12345678, 32'h9ABCDEF0), 1'b1);
        issue(3'b101, 32'd1000, 32'd7, 32'd142, 1'b0);
        held = 32'd142;

        // flush mid-divide: IDLE next cycle, no done, result unchanged
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        chk("flush_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result_held", result, held);
        issue(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);

        // simultaneous start and flush in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b100; srcA = 32'd5; srcB = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", 32'(busy), 32'd0);
        chk("startflush_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);

        // reset mid-multiply
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; srcA = 32'd7; srcB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        issue(3'b000, 32'd7, 32'd9, 32'd63, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
